// File: rtl/calc_engine.sv
// ============================================================================
// Module   : calc_engine
// Brief    : Multi-port two-cycle request capture, per-port pending FIFOs,
//            round-robin arbitration onto one shared registered ALU.
// Options  : CALC_MUL_EN - when defined, cmd 3 is a multiply; otherwise
//            cmd 3 is an invalid command and no multiplier is built.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module calc_engine #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 2,
   parameter int QDEPTH     = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*4-1:0]          cmd_in,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_PORTS*TAG_WIDTH-1:0]  tag_in,
   output logic [NUM_PORTS*2-1:0]          out_resp,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_PORTS*TAG_WIDTH-1:0]  out_tag,
   output logic [NUM_PORTS-1:0]            out_full
);

   localparam int c_AW = $clog2(QDEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int c_SW = $clog2(DATA_WIDTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OP2  = 1'b1
   } state_t;

   logic [NUM_PORTS-1:0]  w_empty;
   logic [NUM_PORTS-1:0]  w_pop;
   logic [3:0]            w_head_cmd [NUM_PORTS];
   logic [TAG_WIDTH-1:0]  w_head_tag [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_head_a   [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_head_b   [NUM_PORTS];

   genvar p;
   generate
      for (p = 0; p < NUM_PORTS; p++) begin : g_port
         state_t                r_state;
         state_t                w_state_nxt;
         logic [3:0]            r_cmd;
         logic [TAG_WIDTH-1:0]  r_tag;
         logic [DATA_WIDTH-1:0] r_op1;
         logic [3:0]            r_mem_cmd [QDEPTH];
         logic [TAG_WIDTH-1:0]  r_mem_tag [QDEPTH];
         logic [DATA_WIDTH-1:0] r_mem_a   [QDEPTH];
         logic [DATA_WIDTH-1:0] r_mem_b   [QDEPTH];
         logic [c_AW-1:0]       r_wptr;
         logic [c_AW-1:0]       r_rptr;
         logic [c_CW-1:0]       r_count;
         logic                  w_full;
         logic                  w_capture;
         logic                  w_push;

         // A request is only accepted while the FIFO has room, so the push
         // one cycle later can never overflow it.
         assign w_full    = (r_count == c_CW'(QDEPTH));
         assign w_capture = (r_state == ST_IDLE) && (cmd_in[4*p +: 4] != 4'd0) && !w_full;
         assign w_push    = (r_state == ST_OP2);

         assign out_full[p]   = w_full;
         assign w_empty[p]    = (r_count == '0);
         assign w_head_cmd[p] = r_mem_cmd[r_rptr];
         assign w_head_tag[p] = r_mem_tag[r_rptr];
         assign w_head_a[p]   = r_mem_a[r_rptr];
         assign w_head_b[p]   = r_mem_b[r_rptr];

         // Next-state: IDLE waits for an accepted command, OP2 lasts one cycle
         always_comb begin
            w_state_nxt = r_state;
            case (r_state)
               ST_IDLE: if (w_capture) w_state_nxt = ST_OP2;
               ST_OP2:  w_state_nxt = ST_IDLE;
               default: w_state_nxt = ST_IDLE;
            endcase
         end

         // State register and first-operand capture
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_state <= ST_IDLE;
               r_cmd   <= '0;
               r_tag   <= '0;
               r_op1   <= '0;
            end else begin
               r_state <= w_state_nxt;
               if (w_capture) begin
                  r_cmd <= cmd_in[4*p +: 4];
                  r_tag <= tag_in[TAG_WIDTH*p +: TAG_WIDTH];
                  r_op1 <= data_in[DATA_WIDTH*p +: DATA_WIDTH];
               end
            end
         end

         // FIFO pointers and occupancy; pointers wrap naturally at QDEPTH
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push)   r_wptr <= r_wptr + 1'b1;
               if (w_pop[p]) r_rptr <= r_rptr + 1'b1;
               case ({w_push, w_pop[p]})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end

         // FIFO storage write; contents are don't-care while empty
         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem_cmd[r_wptr] <= r_cmd;
               r_mem_tag[r_wptr] <= r_tag;
               r_mem_a[r_wptr]   <= r_op1;
               r_mem_b[r_wptr]   <= data_in[DATA_WIDTH*p +: DATA_WIDTH];
            end
         end
      end
   endgenerate

   logic [c_PW-1:0] r_rr;
   logic [c_PW-1:0] w_rr_nxt;
   logic [c_PW-1:0] w_grant;
   logic            w_grant_vld;

   // Round-robin search beginning at the port after the last one granted
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = r_rr;
      w_rr_nxt    = r_rr;
      w_pop       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!w_grant_vld && !w_empty[c_PW'((int'(r_rr) + k) % NUM_PORTS)]) begin
            w_grant_vld = 1'b1;
            w_grant     = c_PW'((int'(r_rr) + k) % NUM_PORTS);
         end
      end
      if (w_grant_vld) begin
         w_pop[w_grant] = 1'b1;
         w_rr_nxt       = c_PW'((int'(w_grant) + 1) % NUM_PORTS);
      end
   end

   logic [3:0]            w_cmd;
   logic [DATA_WIDTH-1:0] w_a;
   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH:0]   w_sum;
   logic [1:0]            w_res_resp;
   logic [DATA_WIDTH-1:0] w_res_data;

   assign w_cmd = w_head_cmd[w_grant];
   assign w_a   = w_head_a[w_grant];
   assign w_b   = w_head_b[w_grant];
   assign w_sum = {1'b0, w_a} + {1'b0, w_b};

`ifdef CALC_MUL_EN
   logic [2*DATA_WIDTH-1:0] w_prod;
   assign w_prod = {{DATA_WIDTH{1'b0}}, w_a} * {{DATA_WIDTH{1'b0}}, w_b};
`endif

   // Shared ALU on the granted FIFO head; error responses carry zero data
   always_comb begin
      w_res_resp = 2'd1;
      w_res_data = '0;
      case (w_cmd)
         4'd1: if (w_sum[DATA_WIDTH]) w_res_resp = 2'd2;
               else                   w_res_data = w_sum[DATA_WIDTH-1:0];
         4'd2: if (w_b > w_a) w_res_resp = 2'd2;
               else           w_res_data = w_a - w_b;
         4'd5: w_res_data = w_a << w_b[c_SW-1:0];
         4'd6: w_res_data = w_a >> w_b[c_SW-1:0];
`ifdef CALC_MUL_EN
         4'd3: if (w_prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0) w_res_resp = 2'd2;
               else w_res_data = w_prod[DATA_WIDTH-1:0];
`endif
         default: w_res_resp = 2'd3;
      endcase
   end

   // Registered response on the granted port only; all other ports read zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr     <= '0;
         out_resp <= '0;
         out_data <= '0;
         out_tag  <= '0;
      end else begin
         r_rr     <= w_rr_nxt;
         out_resp <= '0;
         out_data <= '0;
         out_tag  <= '0;
         if (w_grant_vld) begin
            out_resp[2*int'(w_grant) +: 2]                   <= w_res_resp;
            out_data[DATA_WIDTH*int'(w_grant) +: DATA_WIDTH] <= w_res_data;
            out_tag[TAG_WIDTH*int'(w_grant) +: TAG_WIDTH]    <= w_head_tag[w_grant];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_engine.sv
// ============================================================================
// Module   : tb_calc_engine
// Brief    : Self-checking bench for calc_engine with a queue-based
//            transaction model; honours CALC_MUL_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_calc_engine;
   localparam int NP = 4;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int QD = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NP*4-1:0]    cmd_in;
   logic [NP*DW-1:0]   data_in;
   logic [NP*TW-1:0]   tag_in;
   logic [NP*2-1:0]    out_resp;
   logic [NP*DW-1:0]   out_data;
   logic [NP*TW-1:0]   out_tag;
   logic [NP-1:0]      out_full;

   always #5 clk = ~clk;

   calc_engine #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .QDEPTH(QD)) dut (
      .clk(clk), .reset(reset), .cmd_in(cmd_in), .data_in(data_in), .tag_in(tag_in),
      .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag), .out_full(out_full)
   );

   typedef struct {
      logic [3:0]    cmd;
      logic [TW-1:0] tag;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } ent_t;

   // Reference model: one pending queue per port, a half-built request per
   // port, and the index of the next port to favour.
   ent_t          mq [NP][$];
   ent_t          m_cap [NP];
   bit            m_op2 [NP];
   int            m_rr;
   logic [1:0]    e_resp [NP];
   logic [DW-1:0] e_data [NP];
   logic [TW-1:0] e_tag  [NP];

   int checks   = 0;
   int failures = 0;
   int full_seen;

   function automatic void ref_alu(input ent_t e, output logic [1:0] r, output logic [DW-1:0] d);
      longint unsigned a = 64'(e.a);
      longint unsigned b = 64'(e.b);
      longint unsigned s;
      r = 2'd1;
      d = '0;
      case (e.cmd)
         4'd1: begin s = a + b; if (s > 64'hFFFF_FFFF) r = 2'd2; else d = 32'(s); end
         4'd2: if (b > a) r = 2'd2; else d = 32'(a - b);
         4'd5: d = 32'(a << (b % 32));
         4'd6: d = 32'(a >> (b % 32));
`ifdef CALC_MUL_EN
         4'd3: begin s = a * b; if ((s >> 32) != 0) r = 2'd2; else d = 32'(s); end
`endif
         default: r = 2'd3;
      endcase
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mq[p].delete();
         m_op2[p]  = 1'b0;
         e_resp[p] = '0;
         e_data[p] = '0;
         e_tag[p]  = '0;
      end
      m_rr = 0;
   endtask

   // One clock edge of the model, evaluated from the pre-edge queue state
   task automatic model_step();
      bit   full_pre [NP];
      bit   granted;
      ent_t e;
      for (int p = 0; p < NP; p++) begin
         full_pre[p] = (mq[p].size() == QD);
         e_resp[p] = '0;
         e_data[p] = '0;
         e_tag[p]  = '0;
      end
      granted = 1'b0;
      for (int k = 0; k < NP; k++) begin
         int q = (m_rr + k) % NP;
         if (!granted && mq[q].size() > 0) begin
            granted = 1'b1;
            e = mq[q].pop_front();
            ref_alu(e, e_resp[q], e_data[q]);
            e_tag[q] = e.tag;
            m_rr = (q + 1) % NP;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (m_op2[p]) begin
            e = m_cap[p];
            e.b = data_in[p*DW +: DW];
            mq[p].push_back(e);
            m_op2[p] = 1'b0;
         end else if (cmd_in[p*4 +: 4] != 4'd0 && !full_pre[p]) begin
            m_cap[p].cmd = cmd_in[p*4 +: 4];
            m_cap[p].tag = tag_in[p*TW +: TW];
            m_cap[p].a   = data_in[p*DW +: DW];
            m_cap[p].b   = '0;
            m_op2[p]     = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input int p, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", name, p, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < NP; p++) begin
         chk("resp", p, DW'(out_resp[p*2 +: 2]), DW'(e_resp[p]));
         chk("data", p, out_data[p*DW +: DW], e_data[p]);
         chk("tag",  p, DW'(out_tag[p*TW +: TW]), DW'(e_tag[p]));
         chk("full", p, DW'(out_full[p]), DW'(mq[p].size() == QD));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_step();
      #1;
      check_all();
   endtask

   task automatic set_port(input int p, input logic [3:0] c, input logic [TW-1:0] t, input logic [DW-1:0] d);
      cmd_in[p*4 +: 4]   = c;
      tag_in[p*TW +: TW] = t;
      data_in[p*DW +: DW] = d;
   endtask

   task automatic clear_all();
      cmd_in  = '0;
      tag_in  = '0;
      data_in = '0;
   endtask

   // Single request on one idle port; returns on the response cycle
   task automatic run_one(input int p, input logic [3:0] c, input logic [TW-1:0] t,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      set_port(p, c, t, a);
      tick();
      set_port(p, 4'd0, '0, b);
      tick();
      clear_all();
      tick();
   endtask

   logic [3:0] cmd_tab [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd15};

   initial begin
      reset = 1'b1;
      clear_all();
      model_reset();
      #12;
      check_all();
      reset = 1'b0;

      // Basic add with tag echo
      run_one(0, 4'd1, 2'd2, 32'd5, 32'd7);
      chk("add_resp", 0, DW'(out_resp[1:0]), 32'd1);
      chk("add_data", 0, out_data[31:0], 32'd12);
      chk("add_tag",  0, DW'(out_tag[1:0]), 32'd2);
      tick();

      // Add overflow on port 1 and sub underflow on port 2 together
      set_port(1, 4'd1, 2'd1, 32'hFFFF_FFFF);
      set_port(2, 4'd2, 2'd3, 32'd3);
      tick();
      set_port(1, 4'd0, 2'd0, 32'd1);
      set_port(2, 4'd0, 2'd0, 32'd4);
      tick();
      clear_all();
      tick();
      chk("ovf_resp", 1, DW'(out_resp[3:2]), 32'd2);
      chk("ovf_data", 1, out_data[63:32], 32'd0);
      tick();
      chk("udf_resp", 2, DW'(out_resp[5:4]), 32'd2);
      tick();

      // Shift amount uses only the low five bits
      run_one(3, 4'd5, 2'd0, 32'd1, 32'h21);
      chk("shl_resp", 3, DW'(out_resp[7:6]), 32'd1);
      chk("shl_data", 3, out_data[127:96], 32'd2);
      run_one(3, 4'd7, 2'd1, 32'd9, 32'd9);
      chk("inv_resp", 3, DW'(out_resp[7:6]), 32'd3);
      chk("inv_data", 3, out_data[127:96], 32'd0);
      run_one(3, 4'd3, 2'd2, 32'd6, 32'd7);
`ifdef CALC_MUL_EN
      chk("mul_resp", 3, DW'(out_resp[7:6]), 32'd1);
      chk("mul_data", 3, out_data[127:96], 32'd42);
`else
      chk("mul_resp", 3, DW'(out_resp[7:6]), 32'd3);
      chk("mul_data", 3, out_data[127:96], 32'd0);
`endif
      tick();

      // All ports issue on the same edges; arbiter serves 0,1,2,3
      for (int p = 0; p < NP; p++) set_port(p, 4'd1, TW'(p), 32'(p));
      tick();
      for (int p = 0; p < NP; p++) set_port(p, 4'd0, '0, 32'd100);
      tick();
      clear_all();
      for (int p = 0; p < NP; p++) begin
         tick();
         chk("rr_resp", p, DW'(out_resp[p*2 +: 2]), 32'd1);
         chk("rr_data", p, out_data[p*DW +: DW], 32'(100 + p));
      end
      tick();

      // Port 0 streams requests while ports 1-3 keep the arbiter busy
      full_seen = 0;
      for (int i = 0; i < 24; i++) begin
         set_port(0, 4'd1, TW'(i), 32'(i));
         for (int p = 1; p < NP; p++) set_port(p, 4'd2, TW'(p), 32'($urandom_range(1000, 2000)));
         tick();
         if (out_full[0]) full_seen = 1;
      end
      chk("p0_full_seen", 0, 32'(full_seen), 32'd1);
      clear_all();
      repeat (20) tick();

      // Randomised traffic on all ports
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < NP; p++) begin
            logic [DW-1:0] d;
            case ($urandom_range(3))
               0:       d = 32'hFFFF_FFFF;
               1:       d = 32'($urandom_range(100));
               default: d = $urandom;
            endcase
            set_port(p, cmd_tab[$urandom_range(9)], TW'($urandom), d);
         end
         tick();
      end
      clear_all();
      repeat (20) tick();

      // Queue entries on port 2 behind busy ports, then reset mid-flight
      for (int i = 0; i < 6; i++) begin
         for (int p = 0; p < NP; p++)
            if (p != 2) set_port(p, 4'd1, TW'(p), 32'(i));
         set_port(2, (i < 4 && i % 2 == 0) ? 4'd1 : 4'd0, 2'd3, 32'(i));
         tick();
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_resp_all", 0, DW'(out_resp), 32'd0);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      clear_all();
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
